// File: rtl/nx_node_receiver_pkg.sv
// Node message, signal, command and slot encodings shared by the NX node receiver.
// These are the NXConstants/NXISA definitions; the receiver files import them and keep no local copies.
package nx_node_receiver_pkg;

    typedef enum logic [1:0] {
        NODE_COMMAND_LOAD    = 2'd0,
        NODE_COMMAND_SIGNAL  = 2'd1,
        NODE_COMMAND_MEMORY  = 2'd2,
        NODE_COMMAND_CONTROL = 2'd3
    } node_command_t;

    typedef enum logic [1:0] {
        NODE_SIG_SLOT_PRESERVE = 2'd0,
        NODE_SIG_SLOT_INVERSE  = 2'd1,
        NODE_SIG_SLOT_LOWER    = 2'd2,
        NODE_SIG_SLOT_UPPER    = 2'd3
    } node_sig_slot_t;

    typedef struct packed {
        logic [10:0]    address;
        node_sig_slot_t slot;
        logic [7:0]     data;
    } node_signal_t;

    typedef struct packed {
        node_command_t command;
        node_signal_t  payload;
    } node_message_t;

    // Byte lane inside a row: MSB from the address, LSB from the slot rule.
    function automatic logic [1:0] node_lane(input logic addr_lsb, input node_sig_slot_t slot,
                                             input logic core_slot);
        logic s;
        case (slot)
            NODE_SIG_SLOT_PRESERVE: s = core_slot;
            NODE_SIG_SLOT_INVERSE:  s = ~core_slot;
            NODE_SIG_SLOT_LOWER:    s = 1'b0;
            default:                s = 1'b1;
        endcase
        return {addr_lsb, s};
    endfunction

endpackage

// File: rtl/nx_node_rx_fifo.sv
// Circular inbound message buffer for the node receiver.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module nx_node_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign o_full  = (count_q == (PTR_W+1)'(DEPTH));
    assign o_empty = (count_q == '0);
    assign push_ok = i_push & ~o_full;
    assign pop_ok  = i_pop & ~o_empty;
    assign o_head  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        count_d  = count_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy gates every use of it.
    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= i_push_data;
        end
    end

endmodule

// File: rtl/nx_node_receiver.sv
// Node receiver: buffers inbound node messages and writes SIGNALs to data RAM, LOADs to instruction RAM.
// Optional NX_NODE_RX_COUNT_EN adds o_rx_count, a saturating count of retired SIGNAL/LOAD messages.
module nx_node_receiver
    import nx_node_receiver_pkg::*;
#(
    parameter int RAM_ADDR_W = 10,
    parameter int RAM_DATA_W = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_slot,
    input  node_message_t         i_msg_data,
    input  logic                  i_msg_valid,
    output logic                  o_msg_ready,
    input  logic                  i_data_busy,
    output logic [RAM_ADDR_W-1:0] o_data_addr,
    output logic [RAM_DATA_W-1:0] o_data_wr_data,
    output logic [RAM_DATA_W-1:0] o_data_wr_strb,
    output logic [RAM_ADDR_W-1:0] o_inst_addr,
    output logic [RAM_DATA_W-1:0] o_inst_wr_data,
    output logic [RAM_DATA_W-1:0] o_inst_wr_strb,
    output logic                  o_idle,
    output logic                  o_error
`ifdef NX_NODE_RX_COUNT_EN
    ,
    output logic [15:0]           o_rx_count
`endif
);

    localparam int MSG_W = $bits(node_message_t);

    logic                  ready_en_q;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic [MSG_W-1:0]      head_bits;
    node_message_t         head;
    logic [1:0]            lane;
    logic [RAM_ADDR_W-1:0] row;
    logic [RAM_DATA_W-1:0] wr_data;
    logic [RAM_DATA_W-1:0] wr_strb;
    logic                  is_sig;
    logic                  is_load;
    logic                  is_bad;
    logic                  sig_wr;

    // Held low through reset and released on the first edge after it.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
        end
    end

    assign o_msg_ready = ready_en_q & ~full;
    assign push        = i_msg_valid & o_msg_ready;

    nx_node_rx_fifo #(
        .WIDTH (MSG_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (push),
        .i_push_data (i_msg_data),
        .i_pop       (pop),
        .o_head      (head_bits),
        .o_full      (full),
        .o_empty     (empty)
    );

    assign head    = node_message_t'(head_bits);
    assign lane    = node_lane(head.payload.address[0], head.payload.slot, i_slot);
    assign row     = RAM_ADDR_W'(head.payload.address[10:1]);
    assign wr_data = {(RAM_DATA_W/8){head.payload.data}};
    assign wr_strb = {{(RAM_DATA_W-8){1'b0}}, 8'hFF} << {lane, 3'b000};

    assign is_sig  = ~empty & (head.command == NODE_COMMAND_SIGNAL);
    assign is_load = ~empty & (head.command == NODE_COMMAND_LOAD);
    assign is_bad  = ~empty & ~is_sig & ~is_load;
    assign sig_wr  = is_sig & ~i_data_busy;
    // A SIGNAL head waits for the data RAM, stalling everything queued behind it.
    assign pop     = sig_wr | is_load | is_bad;

    assign o_data_addr    = sig_wr  ? row     : '0;
    assign o_data_wr_data = sig_wr  ? wr_data : '0;
    assign o_data_wr_strb = sig_wr  ? wr_strb : '0;
    assign o_inst_addr    = is_load ? row     : '0;
    assign o_inst_wr_data = is_load ? wr_data : '0;
    assign o_inst_wr_strb = is_load ? wr_strb : '0;
    assign o_error        = is_bad;
    assign o_idle         = empty;

`ifdef NX_NODE_RX_COUNT_EN
    logic [15:0] rx_count_q, rx_count_d;

    always_comb begin
        rx_count_d = rx_count_q;
        if ((sig_wr | is_load) && (rx_count_q != 16'hFFFF)) begin
            rx_count_d = rx_count_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rx_count_q <= '0;
        end else begin
            rx_count_q <= rx_count_d;
        end
    end

    assign o_rx_count = rx_count_q;
`endif

endmodule
